// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// sync_fifo_pkg : shared access-mode encoding and sizing helper for the FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    // Access mode is {write accepted, read accepted}
    typedef enum logic [1:0] {
        ACC_IDLE = 2'b00,
        READ     = 2'b01,
        WRITE    = 2'b10,
        BOTH     = 2'b11
    } access_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_ram.sv
// ============================================================================
// sync_fifo_ram : 1W/1R storage; async read (FWFT) or registered read port
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int FWFT       = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          we_i,
    input  logic [$clog2(FIFO_DEPTH)-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          re_i,
    input  logic [$clog2(FIFO_DEPTH)-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]         rdata_o
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_async_read
            logic w_unused_ok;
            assign w_unused_ok = rst_i & re_i;
            assign rdata_o     = mem[raddr_i];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rdata_q <= '0;
                end else if (re_i) begin
                    rdata_q <= mem[raddr_i];
                end
            end
            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sync_fifo_flagged.sv
// ============================================================================
// sync_fifo_flagged : single-clock FIFO with occupancy count, threshold flags
//                     and sticky overflow/underflow indicators
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_fifo_flagged
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int FWFT       = 1,
    parameter int AFULL_THR  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THR = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic                                write_i,
    input  logic [DATA_WIDTH-1:0]               wr_data_i,
    input  logic                                read_i,
    output logic [DATA_WIDTH-1:0]               rd_data_o,
    output logic                                rd_valid_o,
    output logic                                full_o,
    output logic                                empty_o,
    output logic                                almost_full_o,
    output logic                                almost_empty_o,
    output logic [cnt_width(FIFO_DEPTH)-1:0]    count_o,
    output logic                                overflow_o,
    output logic                                underflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = cnt_width(FIFO_DEPTH);

    localparam logic [CW-1:0] c_depth      = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_afull_thr  = CW'(AFULL_THR);
    localparam logic [CW-1:0] c_aempty_thr = CW'(AEMPTY_THR);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          unf_q,    unf_d;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    access_e       w_access;

    // Flags come only from the registered count: no input-to-output paths
    assign w_full   = (count_q == c_depth);
    assign w_empty  = (count_q == '0);
    assign w_wr_acc = write_i & ~w_full  & ~clear_i;
    assign w_rd_acc = read_i  & ~w_empty & ~clear_i;
    assign w_access = access_e'({w_wr_acc, w_rd_acc});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            ovf_d = ovf_q | (write_i & w_full);
            unf_d = unf_q | (read_i  & w_empty);
            case (w_access)
                WRITE: begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                end
                READ: begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                end
                BOTH: begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FWFT       (FWFT)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .re_i    (w_rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data_o)
    );

    generate
        if (FWFT != 0) begin : g_fwft_valid
            assign rd_valid_o = ~w_empty;
        end else begin : g_reg_valid
            logic rd_valid_q;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= w_rd_acc;
                end
            end
            assign rd_valid_o = rd_valid_q;
        end
    endgenerate

    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (count_q >= c_afull_thr);
    assign almost_empty_o = (count_q <= c_aempty_thr);
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

`default_nettype wire
